// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: symbol and disparity types plus the four
// control-period symbols sent during blanking.
package hdmi_pkg;

    typedef logic [9:0]        tmds_sym_t;
    typedef logic signed [4:0] disp_t;

    localparam tmds_sym_t CTRL_00 = 10'b1101010100;
    localparam tmds_sym_t CTRL_01 = 10'b0010101011;
    localparam tmds_sym_t CTRL_10 = 10'b0101010100;
    localparam tmds_sym_t CTRL_11 = 10'b1010101011;

    function automatic tmds_sym_t ctrl_symbol(input logic [1:0] c);
        tmds_sym_t sym;
        case (c)
            2'b00:   sym = CTRL_00;
            2'b01:   sym = CTRL_01;
            2'b10:   sym = CTRL_10;
            default: sym = CTRL_11;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/hdmi_tmds_encoder_popcount8.sv
// Combinational ones counter for an 8-bit word.
module popcount8 (
    input  logic [7:0] bits,
    output logic [3:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            count = count + {3'b000, bits[i]};
        end
    end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Per-channel TMDS 8b/10b encoder: input register, transition minimisation,
// then DC balance against a running disparity. Three pipeline registers.
module hdmi_tmds_encoder
    import hdmi_pkg::*;
(
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    output logic [9:0] tmds_data
);

    logic [7:0] s1_din;
    logic       s1_de;
    logic [1:0] s1_c;
    logic [3:0] s1_n1;

    logic [8:0] qm_next;
    logic [3:0] qm_n1;

    logic [8:0] s2_qm;
    logic [3:0] s2_n1q;
    logic       s2_de;
    logic [1:0] s2_c;

    disp_t      cnt;
    disp_t      cnt_next;
    tmds_sym_t  sym_next;

    popcount8 u_pop_din (
        .bits  (s1_din),
        .count (s1_n1)
    );

    // Chain is built in a block-local vector so each bit sees its finished predecessor.
    always_comb begin
        logic       use_xnor;
        logic [8:0] q;
        use_xnor = (s1_n1 > 4'd4) || ((s1_n1 == 4'd4) && !s1_din[0]);
        q        = '0;
        q[0]     = s1_din[0];
        for (int unsigned i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ s1_din[i]) : (q[i-1] ^ s1_din[i]);
        end
        q[8]    = ~use_xnor;
        qm_next = q;
    end

    popcount8 u_pop_qm (
        .bits  (qm_next[7:0]),
        .count (qm_n1)
    );

    always_comb begin
        disp_t n1q;
        disp_t n0q;
        disp_t diff;
        disp_t qm8_x2;
        disp_t nqm8_x2;
        n1q      = disp_t'({1'b0, s2_n1q});
        n0q      = 5'sd8 - n1q;
        diff     = n1q - n0q;
        qm8_x2   = s2_qm[8] ? 5'sd2 : 5'sd0;
        nqm8_x2  = s2_qm[8] ? 5'sd0 : 5'sd2;
        sym_next = '0;
        cnt_next = cnt;
        if ((cnt == '0) || (n1q == n0q)) begin
            sym_next = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
            cnt_next = s2_qm[8] ? (cnt + diff) : (cnt - diff);
        end else if ((!cnt[4] && (n1q > n0q)) || (cnt[4] && (n0q > n1q))) begin
            sym_next = {1'b1, s2_qm[8], ~s2_qm[7:0]};
            cnt_next = cnt + qm8_x2 - diff;
        end else begin
            sym_next = {1'b0, s2_qm[8], s2_qm[7:0]};
            cnt_next = cnt - nqm8_x2 + diff;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_din    <= '0;
            s1_de     <= 1'b0;
            s1_c      <= '0;
            s2_qm     <= '0;
            s2_n1q    <= '0;
            s2_de     <= 1'b0;
            s2_c      <= '0;
            cnt       <= '0;
            tmds_data <= CTRL_00;
        end else begin
            s1_din <= din;
            s1_de  <= de;
            s1_c   <= {c1, c0};
            s2_qm  <= qm_next;
            s2_n1q <= qm_n1;
            s2_de  <= s1_de;
            s2_c   <= s1_c;
            if (s2_de) begin
                tmds_data <= sym_next;
                cnt       <= cnt_next;
            end else begin
                tmds_data <= ctrl_symbol(s2_c);
                cnt       <= '0;
            end
        end
    end

endmodule

// File: doc/hdmi_tmds_encoder.md
# hdmi_tmds_encoder

Per-channel TMDS 8b/10b encoder for the HDMI transmit path. Runs in the pixel clock domain and sits directly upstream of the 10:1 serializer, which consumes `tmds_data` unchanged. During active video it converts one 8-bit colour component per cycle into a transition-minimised, DC-balanced 10-bit symbol. During blanking it emits one of four control symbols. Three instances (B/G/R) form one link; `c1:c0` carries HSYNC/VSYNC on the blue channel and is tied to 0 on green and red.

## Interface
Parameters:
- none; widths are fixed by the TMDS standard.

Ports:
- `pixel_clk`  in  1  pixel clock, 1x rate; the serializer's `serial_clk_5x` is derived from it
- `rst_n`  in  1  asynchronous, active-low reset
- `de`  in  1  data enable: 1 = active video, 0 = control period
- `din`  in  8  pixel component, sampled when `de` = 1
- `c0`  in  1  control bit 0, sampled when `de` = 0
- `c1`  in  1  control bit 1, sampled when `de` = 0
- `tmds_data`  out  10  encoded symbol, registered; bit 0 is transmitted first

## Operation
- Stage 1: register `din`, `de`, `c1`, `c0`. Compute n1 = popcount(`din`).
- Stage 2: choose the minimisation mode.
  - XNOR mode (q_m[8] = 0) when n1 > 4, or when n1 = 4 and `din`[0] = 0.
  - Otherwise XOR mode (q_m[8] = 1).
  - q_m[0] = `din`[0].
  - For i = 1..7: q_m[i] = q_m[i-1] XOR/XNOR `din`[i].
  - Register q_m[8:0] and n1q = popcount(q_m[7:0]). n0q = 8 − n1q.
- Stage 3: DC balance against a running disparity `cnt` (5-bit signed; range −10..+10 never overflows).
  - Control period (`de` = 0): `cnt` ← 0, and the output is the control code for `{c1,c0}`:
    - 00 → 10'b1101010100 (0x354)
    - 01 → 0x0AB
    - 10 → 0x154
    - 11 → 0x2AB
  - Balanced case, when `cnt` = 0 or n1q = n0q:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
    - `cnt` += q_m[8] ? (n1q − n0q) : (n0q − n1q)
  - Invert case, when (`cnt` > 0 and n1q > n0q) or (`cnt` < 0 and n0q > n1q):
    - out = {1, q_m[8], ~q_m[7:0]}
    - `cnt` += 2·q_m[8] + (n0q − n1q)
  - Otherwise:
    - out = {0, q_m[8], q_m[7:0]}
    - `cnt` += −2·(~q_m[8]) + (n1q − n0q)
- All arithmetic is signed with at least 5 bits. Sign-extend popcounts before subtracting.
- No FSM beyond `cnt`. Every cycle produces exactly one symbol; there is no back-pressure.

## Timing
- Latency: 3 `pixel_clk` cycles from input sample to `tmds_data`. `de`, `c1` and `c0` travel in the same pipeline as `din`.
- Reset (`rst_n` low, asynchronous) forces:
  - all pipeline registers to 0 (delayed `de` = 0, delayed `{c1,c0}` = 00);
  - `cnt` = 0;
  - `tmds_data` = 0x354.
  - For the first 3 cycles after release, 0x354 continues to be emitted.
- Reset asserted mid-frame takes effect immediately, with no glitch beyond the asynchronous clear. Encoding restarts from `cnt` = 0.
- `de` falling: the first control symbol appears 3 cycles later, and `cnt` is 0 on the following cycle.
- `de` rising: the first data symbol is encoded with `cnt` = 0.
- Back-to-back `de` toggles on every cycle are legal. Each symbol follows its own `de`.

## Structure
- Shared package `hdmi_pkg`:
  - `CTRL_00`, `CTRL_01`, `CTRL_10`, `CTRL_11` symbol constants;
  - `tmds_sym_t` (logic [9:0]);
  - `disp_t` (signed [4:0]).
- One natural sub-module, `popcount8`: combinational 8-bit ones counter, 4-bit result. It is instantiated twice (for `din` and for q_m[7:0]).

## Test plan
- Reset: hold `rst_n` = 0 with random inputs → `tmds_data` = 0x354. After release, 3 more cycles of 0x354.
- Control codes: `de` = 0 with `{c1,c0}` = 00/01/10/11 → 0x354/0x0AB/0x154/0x2AB, each after 3 cycles.
- Zeros stream: `de` = 1, `din` = 0x00 repeated from `cnt` = 0.
  - Output: 0x100, 0x3FF, 0x100, 0x3FF.
  - `cnt` after each symbol: −8, +2, −6, +4.
- Ones start: `de` = 1, `din` = 0xFF from `cnt` = 0 → 0x200, `cnt` = −8. Then drop `de` → control symbol and `cnt` = 0.
- Random soak: 100k random `din`/`de`/`c` values, checked against a behavioural model.
  - Bit-exact match on every symbol.
  - Cumulative output disparity stays within ±20 during each active run.
  - A reference decoder recovers `din`.
- Mid-stream reset: pulse `rst_n` low for 1 cycle during active video → `tmds_data` = 0x354 immediately. The next data symbol after refill is encoded as from `cnt` = 0.
